// File: rtl/dst_uart_pkg.sv
// Shared FSM state encoding and ASCII constants for the distance UART transmitter.
package dst_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_C     = 8'h63;
    localparam logic [7:0] ASCII_M     = 8'h6D;

    // Non-decimal nibbles are shown as '?' rather than wrapping into punctuation.
    function automatic logic [7:0] digit_to_ascii(input logic [7:0] d);
        return (d <= 8'd9) ? (ASCII_ZERO + d) : ASCII_QMARK;
    endfunction

endpackage

// File: rtl/dst_uart_tx_if.sv
// Host-side bundle of the distance transmitter and the internal byte-serialiser link.
interface dst_uart_tx_if #(
    parameter int BCD_LEN = 12
) ();
    logic               vld;
    logic [BCD_LEN-1:0] bcd;
    logic               tx;
    logic               busy;
    logic               drop;

    modport master (output vld, bcd, input tx, busy, drop);
    modport slave  (input vld, bcd, output tx, busy, drop);
endinterface

interface dst_uart_byte_if ();
    logic       start;
    logic [7:0] data;
    logic       done;
    logic       tx;

    modport master (output start, data, input done, tx);
    modport slave  (input start, data, output done, tx);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: DIV clocks per bit, done pulses in the last stop-bit cycle so the
// next byte can start without an idle gap.
module uart_tx_byte
    import dst_uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic            clk,
    input  logic            rst_n,
    dst_uart_byte_if.slave  link
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    assign bit_end   = (cnt_q == CW'(DIV - 1));
    assign link.done = (state_q == ST_STOP) && bit_end;
    assign link.tx   = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (link.start) begin
                    state_d = ST_START;
                    shift_d = link.data;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                // Back-to-back: a start request in the final stop cycle goes straight to START.
                if (bit_end) begin
                    if (link.start) begin
                        state_d = ST_START;
                        shift_d = link.data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/dst_uart_tx.sv
// Sends a BCD distance as ASCII digits + CR LF over UART; DST_UART_UNITS_EN inserts " cm"
// before CR LF. A new distance is only accepted while idle; anything else is dropped.
module dst_uart_tx
    import dst_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int BCD_DIGITS = 3,
    parameter int NUM_LEN    = 4,
    parameter int BCD_LEN    = BCD_DIGITS * NUM_LEN
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               I_VLD,
    input  logic [BCD_LEN-1:0] I_BCD,
    output logic               O_TX,
    output logic               O_BUSY,
    output logic               O_DROP
);
    localparam int DIV = CLK_FREQ / BAUD;
`ifdef DST_UART_UNITS_EN
    localparam int UNIT_CHARS = 3;
`else
    localparam int UNIT_CHARS = 0;
`endif
    localparam int NUM_CHARS = BCD_DIGITS + UNIT_CHARS + 2;
    localparam int IW        = $clog2(NUM_CHARS + 1);

    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic [BCD_LEN-1:0] bcd_q, bcd_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               accept;
    logic [BCD_LEN-1:0] bcd_src;
    logic [IW-1:0]      char_sel;
    logic [7:0]         char_ascii;
    logic [7:0]         digit_ascii [BCD_DIGITS];

    dst_uart_byte_if link ();

    uart_tx_byte #(.DIV(DIV)) u_byte (
        .clk   (CLK),
        .rst_n (RST_n),
        .link  (link)
    );

    // The first character is chosen from I_BCD directly so its start bit follows the accept edge.
    assign accept   = I_VLD && !busy_q;
    assign bcd_src  = accept ? I_BCD : bcd_q;
    assign char_sel = accept ? '0 : idx_q;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
        assign digit_ascii[gi] = digit_to_ascii(8'(bcd_src[BCD_LEN-1-gi*NUM_LEN -: NUM_LEN]));
    end

    always_comb begin
        char_ascii = ASCII_LF;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (char_sel == IW'(i)) char_ascii = digit_ascii[i];
        end
`ifdef DST_UART_UNITS_EN
        if (char_sel == IW'(BCD_DIGITS))     char_ascii = ASCII_SPACE;
        if (char_sel == IW'(BCD_DIGITS + 1)) char_ascii = ASCII_C;
        if (char_sel == IW'(BCD_DIGITS + 2)) char_ascii = ASCII_M;
`endif
        if (char_sel == IW'(NUM_CHARS - 2))  char_ascii = ASCII_CR;
    end

    assign link.data = char_ascii;

    always_comb begin
        busy_d     = busy_q;
        idx_d      = idx_q;
        bcd_d      = bcd_q;
        drop_d     = I_VLD && busy_q;
        link.start = 1'b0;
        if (accept) begin
            busy_d     = 1'b1;
            idx_d      = IW'(1);
            bcd_d      = I_BCD;
            link.start = 1'b1;
        end else if (link.done) begin
            if (idx_q < IW'(NUM_CHARS)) begin
                link.start = 1'b1;
                idx_d      = idx_q + 1'b1;
            end else begin
                busy_d = 1'b0;
                idx_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            busy_q <= 1'b0;
            drop_q <= 1'b0;
            bcd_q  <= '0;
            idx_q  <= '0;
        end else begin
            busy_q <= busy_d;
            drop_q <= drop_d;
            bcd_q  <= bcd_d;
            idx_q  <= idx_d;
        end
    end

    assign O_TX   = link.tx;
    assign O_BUSY = busy_q;
    assign O_DROP = drop_q;

endmodule

// File: tb/tb_dst_uart_tx.sv
// Self-checking bench for dst_uart_tx: expected serial waveform derived from the message
// rules (digits, optional DST_UART_UNITS_EN " cm", CR LF) with random distances and noise.
module tb_dst_uart_tx;

    localparam int DIV   = 50000000 / 115200;
    localparam int FRAME = 10 * DIV;
`ifdef DST_UART_UNITS_EN
    localparam logic [11:0] MSG_A      = 12'h400;
    localparam int          EXP_A_BUSY = 34720;
    localparam int          ABORT_C    = 1000;
`else
    localparam logic [11:0] MSG_A      = 12'h123;
    localparam int          EXP_A_BUSY = 21700;
    localparam int          ABORT_C    = -1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_busy_cnt;
    logic [7:0] exp_msg [$];

    dst_uart_tx_if #(.BCD_LEN(12)) host ();

    dst_uart_tx dut (
        .CLK    (clk),
        .RST_n  (rst_n),
        .I_VLD  (host.vld),
        .I_BCD  (host.bcd),
        .O_TX   (host.tx),
        .O_BUSY (host.busy),
        .O_DROP (host.drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_msg(input logic [11:0] bcd);
        exp_msg.delete();
        for (int i = 2; i >= 0; i--) begin
            int d;
            d = int'((bcd >> (4 * i)) & 12'hF);
            exp_msg.push_back((d < 10) ? 8'(48 + d) : 8'h3F);
        end
`ifdef DST_UART_UNITS_EN
        exp_msg.push_back(8'h20);
        exp_msg.push_back(8'h63);
        exp_msg.push_back(8'h6D);
`endif
        exp_msg.push_back(8'h0D);
        exp_msg.push_back(8'h0A);
    endtask

    function automatic logic exp_line(input int k);
        int frame;
        int pos;
        logic [7:0] b;
        frame = k / FRAME;
        pos   = (k % FRAME) / DIV;
        if (frame >= exp_msg.size()) return 1'b1;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = exp_msg[frame];
        return b[pos-1];
    endfunction

    // Call at a negedge. drop_at: cycle to pulse a 0x999 I_VLD (-1 none); fall_vld: pulse
    // I_VLD so it is sampled on the edge where O_BUSY falls; abort_at: cycle to assert reset.
    task automatic send_msg(input logic [11:0] bcd, input int drop_at, input logic fall_vld,
                            input int abort_at);
        int L, wave_err, frame_err, busy_cnt, drop_cnt, drop_err, exp_drops;
        logic [7:0] obs;
        model_msg(bcd);
        L = exp_msg.size() * FRAME;
        wave_err = 0; frame_err = 0; busy_cnt = 0; drop_cnt = 0; drop_err = 0; obs = '0;
        exp_drops = ((drop_at >= 0) ? 1 : 0) + (fall_vld ? 1 : 0);
        host.vld = 1'b1;
        host.bcd = bcd;
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            if (k == 0) check("start_edge", 32'({host.busy, host.tx}), 32'b10);
            if (k == abort_at) begin
                check("pre_abort_wave", 32'(wave_err), 0);
                rst_n = 1'b0;
                #1;
                check("abort_tx", 32'(host.tx), 1);
                check("abort_busy", 32'(host.busy), 0);
                check("abort_drop", 32'(host.drop), 0);
                $display("msg bcd=0x%03h aborted by reset at cycle %0d", bcd, k);
                host.vld = 1'b0;
                return;
            end
            if (host.drop) drop_cnt++;
            if (host.drop !== ((drop_at >= 0 && k == drop_at + 1) || (fall_vld && k == L)))
                drop_err++;
            if (k < L) begin
                if (host.busy) busy_cnt++;
                if (host.tx !== exp_line(k)) begin
                    wave_err++;
                    frame_err++;
                end
                if ((k % FRAME) / DIV >= 1 && (k % FRAME) / DIV <= 8 && (k % DIV) == DIV / 2)
                    obs[(k % FRAME) / DIV - 1] = host.tx;
                if ((k % FRAME) == FRAME - 1) begin
                    check($sformatf("byte%0d", k / FRAME), 32'(obs), 32'(exp_msg[k / FRAME]));
                    check($sformatf("timing%0d", k / FRAME), 32'(frame_err), 0);
                    frame_err = 0;
                end
            end else begin
                check("busy_fall", 32'(host.busy), 0);
                check("idle_tx", 32'(host.tx), 1);
            end
            host.vld = 1'b0;
            host.bcd = 12'($urandom);
            if (drop_at >= 0 && k == drop_at) begin
                host.vld = 1'b1;
                host.bcd = 12'h999;
            end
            if (fall_vld && k == L - 1) begin
                host.vld = 1'b1;
                host.bcd = 12'h777;
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'(L));
        check("drop_count", 32'(drop_cnt), 32'(exp_drops));
        check("drop_position", 32'(drop_err), 0);
        last_busy_cnt = busy_cnt;
        $display("msg bcd=0x%03h chars=%0d busy=%0d drops=%0d wave_err=%0d",
                 bcd, exp_msg.size(), busy_cnt, drop_cnt, wave_err);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (host.tx !== 1'b1 || host.busy !== 1'b0 || host.drop !== 1'b0) bad++;
            host.vld = 1'b0;
            host.bcd = 12'($urandom);
        end
        check(tag, 32'(bad), 0);
    endtask

    initial begin
        logic [11:0] bcd_c, bcd_d;
        host.vld = 1'b1;
        host.bcd = 12'h555;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(host.tx), 1);
        check("reset_busy", 32'(host.busy), 0);
        check("reset_drop", 32'(host.drop), 0);
        host.vld = 1'b0;
        rst_n = 1'b1;
        idle_check("idle_after_reset", 20);

        send_msg(MSG_A, 5000, 1'b0, -1);
        check("busy_len_exact", 32'(last_busy_cnt), 32'(EXP_A_BUSY));
        idle_check("idle_after_a", 10);

        send_msg(12'h4A0, -1, 1'b1, -1);
        bcd_c = 12'($urandom);
        send_msg(bcd_c, -1, 1'b0, ABORT_C);
`ifndef DST_UART_UNITS_EN
        idle_check("idle_after_c", 10);
        bcd_d = 12'($urandom);
        send_msg(bcd_d, -1, 1'b0, 1000);
`else
        bcd_d = 12'h0;
`endif
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_check("no_resume_after_abort", 2000);
        $display("last random distances c=0x%03h d=0x%03h", bcd_c, bcd_d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
